reg_word_packer: RTL and testbench



---
 rtl/reg_word_packer_pkg.sv | 17 +
 rtl/reg_word_packer_if.sv | 45 ++++
 rtl/reg_word_packer.sv | 96 +++++++++
 tb/tb_reg_word_packer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_word_packer_pkg.sv
// Shared types and sizing for the 256-bit register-store word packer.
// Block geometry, counter widths and the packer FSM state encoding.
package reg_word_packer_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned BLOCK_W   = 256;
  localparam int unsigned COUNT_W   = 8;

  typedef enum logic [1:0] {
    StFill,
    StWrite,
    StRead,
    StCheck
  } state_e;

endpackage

// File: rtl/reg_word_packer_if.sv
// Word-stream and register-store signals of the packer, bundled with modports.
// master = upstream feeder / register store / controller; slave = the packer.
interface reg_word_packer_if;

  logic                                        inValid;
  logic                                        inReady;
  logic [reg_word_packer_pkg::WORD_W-1:0]      inData;
  logic                                        inLast;
  logic                                        regEN;
  logic                                        regRW;
  logic [reg_word_packer_pkg::BLOCK_W-1:0]     regWrite;
  logic [reg_word_packer_pkg::BLOCK_W-1:0]     regBus;
  logic                                        done;
  logic                                        mismatch;
  logic [reg_word_packer_pkg::COUNT_W-1:0]     blockCount;

  modport master (
    output inValid,
    output inData,
    output inLast,
    output regBus,
    input  inReady,
    input  regEN,
    input  regRW,
    input  regWrite,
    input  done,
    input  mismatch,
    input  blockCount
  );

  modport slave (
    input  inValid,
    input  inData,
    input  inLast,
    input  regBus,
    output inReady,
    output regEN,
    output regRW,
    output regWrite,
    output done,
    output mismatch,
    output blockCount
  );

endinterface

// File: rtl/reg_word_packer.sv
// Packs up to NUM_WORDS upstream words into one block, writes it to the register
// store, reads it back and flags any read-back mismatch.
module reg_word_packer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_word_packer_if.slave  bus
);

  import reg_word_packer_pkg::*;

  localparam int unsigned CntW = $clog2(NUM_WORDS);
  localparam logic [CntW-1:0] LastIdx = CntW'(NUM_WORDS - 1);

  state_e               state_q, state_d;
  logic [BLOCK_W-1:0]   block_q, block_d;
  logic [CntW-1:0]      word_cnt_q, word_cnt_d;
  logic [COUNT_W-1:0]   block_count_q, block_count_d;

  logic ready;
  logic accept;
  logic commit;

  // Ready is gated by reset so nothing is handshaked while the block is held.
  assign ready  = (state_q == StFill) && rst_n;
  assign accept = bus.inValid && ready;
  assign commit = accept && (bus.inLast || (word_cnt_q == LastIdx));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (commit) state_d = StWrite;
      StWrite: state_d = StRead;
      StRead:  state_d = StCheck;
      StCheck: state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.inReady    = ready;
    bus.regEN      = (state_q == StWrite) || (state_q == StRead);
    bus.regRW      = (state_q != StWrite);
    bus.regWrite   = block_q;
    bus.done       = (state_q == StCheck);
    bus.mismatch   = (state_q == StCheck) && (bus.regBus != block_q);
    bus.blockCount = block_count_q;
  end

  // Lane insert: accepted word lands at its arrival slot; CHECK clears for the next block.
  always_comb begin
    block_d    = block_q;
    word_cnt_d = word_cnt_q;
    if (accept) begin
      block_d[word_cnt_q*WORD_W +: WORD_W] = bus.inData;
      word_cnt_d = word_cnt_q + 1'b1;
    end else if (state_q == StCheck) begin
      block_d    = '0;
      word_cnt_d = '0;
    end
  end

  // Completed-block counter wraps silently.
  always_comb begin
    block_count_d = block_count_q;
    if (state_q == StCheck) begin
      block_count_d = block_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      block_q       <= '0;
      word_cnt_q    <= '0;
      block_count_q <= '0;
    end else begin
      block_q       <= block_d;
      word_cnt_q    <= word_cnt_d;
      block_count_q <= block_count_d;
    end
  end

endmodule

// File: tb/tb_reg_word_packer.sv
// Randomized self-checking bench for reg_word_packer against a queue-based model.
module tb_reg_word_packer;

  logic clk;
  logic rst_n;

  reg_word_packer_if bus ();

  reg_word_packer #(
    .WORD_W   (32),
    .NUM_WORDS(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned en_cycles = 0;

  // Model: words received so far, cycles elapsed since commit (0 = filling).
  logic [31:0]  words[$];
  int           phase = 0;
  logic [255:0] exp_block = '0;
  logic [7:0]   exp_count = '0;
  bit           corrupt = 1'b0;

  function automatic logic [255:0] pack_words(input logic [31:0] q[$]);
    logic [255:0] blk;
    blk = '0;
    for (int i = 0; i < q.size(); i++) blk[32*i +: 32] = q[i];
    return blk;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n        = 1'b0;
    bus.inValid  = 1'b1;
    bus.inData   = $urandom;
    bus.inLast   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.regBus = {8{$urandom}};
      #1;
      check1("rst_inReady", bus.inReady, 1'b0);
      check1("rst_regEN", bus.regEN, 1'b0);
      check1("rst_regRW", bus.regRW, 1'b1);
      check_w("rst_regWrite", bus.regWrite, '0);
      check1("rst_done", bus.done, 1'b0);
      check1("rst_mismatch", bus.mismatch, 1'b0);
      check_w("rst_blockCount", 256'(bus.blockCount), '0);
    end
    words.delete();
    phase       = 0;
    exp_count   = '0;
    rst_n       = 1'b1;
    bus.inValid = 1'b0;
  endtask

  task automatic cyc(input bit v, input logic [31:0] d, input bit l);
    bit acc;
    bus.inValid = v;
    bus.inData  = d;
    bus.inLast  = l;
    acc = v && rst_n && (phase == 0);
    @(posedge clk); #1;
    if (phase == 3) begin
      phase     = 0;
      exp_count = exp_count + 8'd1;
    end else if (phase > 0) begin
      phase++;
    end else if (acc) begin
      words.push_back(d);
      if (l || words.size() == 8) begin
        exp_block = pack_words(words);
        words.delete();
        phase = 1;
      end
    end
    bus.regBus = (phase == 3) ? (exp_block ^ 256'(corrupt)) : {8{$urandom}};
    #1;
    check1("inReady", bus.inReady, phase == 0);
    check1("regEN", bus.regEN, (phase == 1) || (phase == 2));
    if (phase == 1 || phase == 2) check1("regRW", bus.regRW, phase == 2);
    check_w("regWrite", bus.regWrite, (phase == 0) ? pack_words(words) : exp_block);
    check1("done", bus.done, phase == 3);
    if (phase == 3) check1("mismatch", bus.mismatch, corrupt);
    check_w("blockCount", 256'(bus.blockCount), 256'(exp_count));
    if (bus.regEN) en_cycles++;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && phase != 0; i++) cyc(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.inValid = 1'b0;
    bus.inData  = '0;
    bus.inLast  = 1'b0;
    bus.regBus  = '0;
    do_reset(2);

    // Full block 1..8, inValid held high.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(i), i == 8);
    check_w("full_block", bus.regWrite,
            256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0);
    check_w("count_after_first", 256'(bus.blockCount), 256'd1);

    // Short block of three words.
    cyc(1'b1, 32'hAAAAAAAA, 1'b0);
    cyc(1'b1, 32'hBBBBBBBB, 1'b0);
    cyc(1'b1, 32'hCCCCCCCC, 1'b1);
    check_w("short_block", bus.regWrite, 256'hCCCCCCCC_BBBBBBBB_AAAAAAAA);
    drain();

    // inValid every other cycle, also while busy.
    for (int i = 0; i < 40; i++) cyc(i % 2 == 0, $urandom, $urandom_range(0, 5) == 0);
    drain();

    // Corrupted read-back, then a clean one.
    corrupt = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, 1'b0);
    drain();
    corrupt = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, 1'b0);
    drain();

    // Random traffic.
    for (int i = 0; i < 80; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0);
    drain();

    // Reset while the five-word block is in its read access.
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, i == 4);
    cyc(1'b0, 32'h0, 1'b0);
    check1("pre_reset_read", bus.regRW && bus.regEN, 1'b1);
    do_reset(2);
    for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, 1'b0);
    drain();
    check_w("count_after_reset", 256'(bus.blockCount), 256'd1);

    // 256 single-word blocks: counter wraps, regEN busy exactly twice per block.
    do_reset(1);
    en_cycles = 0;
    for (int b = 0; b < 256; b++) begin
      cyc(1'b1, $urandom, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0);
    end
    check_w("wrap_count", 256'(bus.blockCount), 256'd0);
    check_w("regEN_total", 256'(en_cycles), 256'd512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
